// File: rtl/vmem_fill.sv
// Rectangle-fill engine in front of the video-memory write port.
// CPU stores pass through with priority; the fill generates one {y, x} write per free cycle.
module vmem_fill #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
  localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);

  state_e      state_q;
  logic [31:0] rect_q;
  logic [2:0]  color_q;
  logic [7:0]  x0_q;
  logic [7:0]  w_q;
  logic [2:0]  fcol_q;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [7:0]  cols_q, cols_d;
  logic [7:0]  rows_q, rows_d;
  logic        done_q;
  logic [15:0] count_q;
  logic [31:0] rdata_q, rdata_d;
  logic        vwe_q;
  logic [15:0] vaddr_q;
  logic [2:0]  vdata_q;

  logic [1:0]  sel;
  logic        wr_ctrl, start_req, abort_req;
  logic        visible, last_col, last_row;
  logic        unused_addr;

  assign sel         = reg_addr_i[3:2];
  assign unused_addr = ^reg_addr_i[1:0];
  assign wr_ctrl     = reg_we_i && (sel == 2'd0);
  // ABORT wins over START in the same CTRL write.
  assign abort_req   = wr_ctrl && reg_wdata_i[1];
  assign start_req   = wr_ctrl && reg_wdata_i[0] && !reg_wdata_i[1];

  // x/y are 9 bits wide so a rectangle running off the screen never wraps back in.
  assign visible  = (x_q < WIDTH_L) && (y_q < HEIGHT_L);
  assign last_col = (cols_q == 8'd1);
  assign last_row = (rows_q == 8'd1);

  always_comb begin
    x_d    = x_q + 9'd1;
    y_d    = y_q;
    cols_d = cols_q - 8'd1;
    rows_d = rows_q;
    if (last_col) begin
      x_d    = {1'b0, x0_q};
      y_d    = y_q + 9'd1;
      cols_d = w_q;
      rows_d = rows_q - 8'd1;
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (sel)
      2'd0:    rdata_d = {30'd0, done_q, (state_q == RUN)};
      2'd1:    rdata_d = rect_q;
      2'd2:    rdata_d = {29'd0, color_q};
      default: rdata_d = {16'd0, count_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rect_q  <= 32'd0;
      color_q <= 3'd0;
      x0_q    <= 8'd0;
      w_q     <= 8'd0;
      fcol_q  <= 3'd0;
      x_q     <= 9'd0;
      y_q     <= 9'd0;
      cols_q  <= 8'd0;
      rows_q  <= 8'd0;
      done_q  <= 1'b0;
      count_q <= 16'd0;
      rdata_q <= 32'd0;
      vwe_q   <= 1'b0;
      vaddr_q <= 16'd0;
      vdata_q <= 3'd0;
    end else begin
      rdata_q <= rdata_d;
      vwe_q   <= 1'b0;

      if (reg_we_i && (sel == 2'd1)) rect_q  <= reg_wdata_i;
      if (reg_we_i && (sel == 2'd2)) color_q <= reg_wdata_i[2:0];

      if (cpu_we_i) begin
        vwe_q   <= 1'b1;
        vaddr_q <= cpu_addr_i;
        vdata_q <= cpu_wdata_i;
      end

      case (state_q)
        IDLE: begin
          if (start_req) begin
            count_q <= 16'd0;
            x_q     <= {1'b0, rect_q[7:0]};
            y_q     <= {1'b0, rect_q[15:8]};
            x0_q    <= rect_q[7:0];
            w_q     <= rect_q[23:16];
            cols_q  <= rect_q[23:16];
            rows_q  <= rect_q[31:24];
            fcol_q  <= color_q;
            if ((rect_q[23:16] == 8'd0) || (rect_q[31:24] == 8'd0)) begin
              done_q <= 1'b1;
            end else begin
              done_q  <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            state_q <= IDLE;
          end else if (!cpu_we_i) begin
            // Clipped pixels still consume the cycle so busy time depends only on w*h.
            if (visible) begin
              vwe_q   <= 1'b1;
              vaddr_q <= {y_q[7:0], x_q[7:0]};
              vdata_q <= fcol_q;
              count_q <= count_q + 16'd1;
            end
            x_q    <= x_d;
            y_q    <= y_d;
            cols_q <= cols_d;
            rows_q <= rows_d;
            if (last_col && last_row) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign vmem_we_o    = vwe_q;
  assign vmem_addr_o  = vaddr_q;
  assign vmem_wdata_o = vdata_q;
  assign busy_o       = (state_q == RUN);

endmodule

// File: tb/tb_vmem_fill.sv
// Directed bench for vmem_fill: write ordering, clipping, CPU priority, abort and reset.
module tb_vmem_fill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [2:0]  cpu_wdata;
  logic        vmem_we;
  logic [15:0] vmem_addr;
  logic [2:0]  vmem_wdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;
  logic [18:0] wq[$];
  logic [18:0] exp_q[$];

  vmem_fill #(.WIDTH(240), .HEIGHT(240)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_we_i    (reg_we),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .vmem_we_o   (vmem_we),
    .vmem_addr_o (vmem_addr),
    .vmem_wdata_o(vmem_wdata),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vmem_we === 1'b1) wq.push_back({vmem_addr, vmem_wdata});
    if (busy === 1'b1) busy_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clk);
    #1;
    reg_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a;
    @(posedge clk);
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    wait_cyc(1);
  endtask

  task automatic check_writes(input string tag, input int s);
    logic [31:0] got;
    check({tag, "_nwr"}, wq.size() - s, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (s + i < wq.size()) ? {13'd0, wq[s + i]} : 32'hDEADBEEF;
      check($sformatf("%s_wr%0d", tag, i), got, {13'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    int s, b, n;
    logic [31:0] d;
    rst_n = 1'b0; reg_we = 1'b0; reg_addr = 4'd0; reg_wdata = 32'd0;
    cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 3'd0;
    wait_cyc(2);
    check("rst_we",    {31'd0, vmem_we}, 32'd0);
    check("rst_addr",  {16'd0, vmem_addr}, 32'd0);
    check("rst_data",  {29'd0, vmem_wdata}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(1);
    reg_rd(4'h0, d); check("rst_ctrl", d, 32'd0);

    // basic 3x2 fill
    reg_wr(4'h4, 32'h0203140A);
    reg_wr(4'h8, 32'd5);
    s = wq.size(); b = busy_cnt;
    reg_wr(4'h0, 32'd1);
    check("t1_busy_now", {31'd0, busy}, 32'd1);
    wait_idle("t1_timeout", 50);
    exp_q.push_back({16'h140A, 3'd5}); exp_q.push_back({16'h140B, 3'd5});
    exp_q.push_back({16'h140C, 3'd5}); exp_q.push_back({16'h150A, 3'd5});
    exp_q.push_back({16'h150B, 3'd5}); exp_q.push_back({16'h150C, 3'd5});
    check_writes("t1", s);
    check("t1_busycyc", busy_cnt - b, 32'd6);
    reg_rd(4'hC, d); check("t1_count", d, 32'd6);
    reg_rd(4'h0, d); check("t1_ctrl", d, 32'd2);

    // clipping at the right and bottom edges
    reg_wr(4'h4, 32'h0204EFEE);
    s = wq.size(); b = busy_cnt;
    reg_wr(4'h0, 32'd1);
    wait_idle("t2_timeout", 50);
    exp_q.push_back({16'hEFEE, 3'd5}); exp_q.push_back({16'hEFEF, 3'd5});
    check_writes("t2", s);
    check("t2_busycyc", busy_cnt - b, 32'd8);
    reg_rd(4'hC, d); check("t2_count", d, 32'd2);

    // CPU stores take priority over a 1x4 fill
    reg_wr(4'h4, 32'h04010605);
    reg_wr(4'h8, 32'd3);
    s = wq.size(); b = busy_cnt;
    reg_wr(4'h0, 32'd1);
    wait_cyc(1);
    cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 3'd7;
    wait_cyc(2);
    cpu_we = 1'b0;
    wait_idle("t3_timeout", 50);
    exp_q.push_back({16'h0605, 3'd3}); exp_q.push_back({16'h1234, 3'd7});
    exp_q.push_back({16'h1234, 3'd7}); exp_q.push_back({16'h0705, 3'd3});
    exp_q.push_back({16'h0805, 3'd3}); exp_q.push_back({16'h0905, 3'd3});
    check_writes("t3", s);
    check("t3_busycyc", busy_cnt - b, 32'd6);
    reg_rd(4'hC, d); check("t3_count", d, 32'd4);

    // w == 0: immediate done, plus an idle pass-through store
    reg_wr(4'h4, 32'h05000000);
    s = wq.size(); b = busy_cnt;
    reg_wr(4'h0, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    reg_rd(4'h0, d); check("t4_ctrl", d, 32'd2);
    cpu_we = 1'b1; cpu_addr = 16'hABCD; cpu_wdata = 3'd2;
    wait_cyc(1);
    cpu_we = 1'b0;
    wait_cyc(1);
    exp_q.push_back({16'hABCD, 3'd2});
    check_writes("t4", s);
    check("t4_busycyc", busy_cnt - b, 32'd0);
    reg_rd(4'hC, d); check("t4_count", d, 32'd0);

    // second START and shadow writes during RUN do not disturb the fill
    reg_wr(4'h4, 32'h02020201);
    reg_wr(4'h8, 32'd6);
    s = wq.size(); b = busy_cnt;
    reg_wr(4'h0, 32'd1);
    reg_wr(4'h4, 32'h0A0A6464);
    reg_wr(4'h8, 32'd1);
    reg_wr(4'h0, 32'd1);
    wait_idle("t5_timeout", 50);
    exp_q.push_back({16'h0201, 3'd6}); exp_q.push_back({16'h0202, 3'd6});
    exp_q.push_back({16'h0301, 3'd6}); exp_q.push_back({16'h0302, 3'd6});
    check_writes("t5", s);
    check("t5_busycyc", busy_cnt - b, 32'd4);
    reg_rd(4'h4, d); check("t5_rect", d, 32'h0A0A6464);
    reg_rd(4'hC, d); check("t5_count", d, 32'd4);

    // abort a full-screen fill after 100 writes
    reg_wr(4'h4, 32'hF0F00000);
    reg_wr(4'h8, 32'd2);
    s = wq.size();
    reg_wr(4'h0, 32'd1);
    wait_cyc(100);
    reg_wr(4'h0, 32'd2);
    wait_cyc(2);
    check("t6_busy", {31'd0, busy}, 32'd0);
    n = wq.size() - s;
    check("t6_nwr_ge100", {31'd0, n >= 100}, 32'd1);
    check("t6_nwr_le101", {31'd0, n <= 101}, 32'd1);
    reg_rd(4'h0, d); check("t6_ctrl", d, 32'd0);
    reg_rd(4'hC, d);
    check("t6_count_le101", {31'd0, d <= 32'd101}, 32'd1);
    check("t6_count_eq_wr", d, n);

    // reset in the middle of a fill
    reg_wr(4'h0, 32'd1);
    wait_cyc(20);
    rst_n = 1'b0;
    wait_cyc(1);
    check("t7_we",    {31'd0, vmem_we}, 32'd0);
    check("t7_addr",  {16'd0, vmem_addr}, 32'd0);
    check("t7_data",  {29'd0, vmem_wdata}, 32'd0);
    check("t7_busy",  {31'd0, busy}, 32'd0);
    check("t7_rdata", reg_rdata, 32'd0);
    rst_n = 1'b1;
    s = wq.size();
    wait_cyc(5);
    check("t7_nowr", wq.size() - s, 32'd0);
    reg_rd(4'h0, d); check("t7_ctrl", d, 32'd0);
    reg_rd(4'hC, d); check("t7_count", d, 32'd0);
    reg_rd(4'h4, d); check("t7_rect", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
